// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared constants and helpers for the pwm_bank PWM block.
package pwm_bank_pkg;
    localparam int DT_W = 4;
    function automatic int period_sel(input int channels);
        return channels;
    endfunction
endpackage

// File: rtl/pwm_bank_channel.sv
// pwm_bank_channel: one PWM channel with shadow/active duty and offset, comparator and output stage.
// Dead-time insertion on out/out_n is built only when PWM_BANK_DEADTIME_EN is defined.
module pwm_bank_channel
    import pwm_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEADTIME = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic [WIDTH-1:0] wr_offset,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] period,
    output logic             out,
    output logic             out_n
);
    if (DEADTIME < 1 || DEADTIME > 15) begin : g_bad_deadtime
        $error("DEADTIME out of range");
    end
    logic [WIDTH-1:0] sh_duty, sh_off, duty, off;
    logic [WIDTH:0] diff;
    logic raw;
    // distance from the offset, wrapped into the (period+1)-long cycle
    assign diff = (cnt >= off) ? {1'b0, cnt} - {1'b0, off}
                               : {1'b0, cnt} + {1'b0, period} + (WIDTH+1)'(1) - {1'b0, off};
    assign raw  = (off <= period) && (diff < {1'b0, duty});
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_duty <= '0;
            sh_off  <= '0;
            duty    <= '0;
            off     <= '0;
        end else begin
            if (load) begin
                duty <= sh_duty;
                off  <= sh_off;
            end
            if (wr) begin
                sh_duty <= wr_duty;
                sh_off  <= wr_offset;
            end
        end
    end
`ifdef PWM_BANK_DEADTIME_EN
    logic raw_q;
    logic [DT_W-1:0] dt, run;
    // run = earlier consecutive cycles at the current raw level, saturating at DEADTIME
    assign run = (raw == raw_q) ? dt : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q <= 1'b0;
            dt    <= '0;
            out   <= 1'b0;
            out_n <= 1'b0;
        end else begin
            raw_q <= raw;
            dt    <= (raw != raw_q) ? DT_W'(1) : (dt == DT_W'(DEADTIME) ? dt : dt + DT_W'(1));
            out   <= raw && run >= DT_W'(DEADTIME);
            out_n <= !raw && run >= DT_W'(DEADTIME);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out <= 1'b0;
        else     out <= raw;
    end
    assign out_n = 1'b0;
`endif
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: bank of PWM channels sharing one counter, with shadowed period/duty/offset applied at wrap on commit.
// Optional dead-time complementary outputs: define PWM_BANK_DEADTIME_EN.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 8,
    parameter int DEFAULT_PERIOD = 2**WIDTH-1,
    parameter int DEADTIME       = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [$clog2(CHANNELS+1)-1:0]   wr_sel,
    input  logic [WIDTH-1:0]                wr_duty,
    input  logic [WIDTH-1:0]                wr_offset,
    input  logic                            commit,
    output logic                            commit_pending,
    output logic                            period_end,
    output logic [CHANNELS-1:0]             out,
    output logic [CHANNELS-1:0]             out_n
);
    localparam int SEL_W = $clog2(CHANNELS+1);
    logic [WIDTH-1:0] cnt, period, sh_period;
    logic wrap, load;
    assign wrap = cnt == period;
    // actives only change as cnt returns to 0, so a shorter period can never strand cnt
    assign load = wrap && (commit_pending || commit);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            period         <= WIDTH'(DEFAULT_PERIOD);
            sh_period      <= WIDTH'(DEFAULT_PERIOD);
            commit_pending <= 1'b0;
            period_end     <= 1'b0;
        end else begin
            cnt            <= wrap ? '0 : cnt + WIDTH'(1);
            period_end     <= wrap;
            commit_pending <= !wrap && (commit_pending || commit);
            if (load) period <= sh_period;
            if (wr_en && wr_sel == SEL_W'(period_sel(CHANNELS))) sh_period <= wr_duty;
        end
    end
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_bank_channel #(.WIDTH(WIDTH), .DEADTIME(DEADTIME)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr_en && wr_sel == SEL_W'(g)),
            .wr_duty  (wr_duty),
            .wr_offset(wr_offset),
            .load     (load),
            .cnt      (cnt),
            .period   (period),
            .out      (out[g]),
            .out_n    (out_n[g])
        );
    end
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent PWM channels, 1..16.
REQ-002 Parameter WIDTH, default 8: counter, period, duty and offset width in bits, 2..16.
REQ-003 Parameter DEFAULT_PERIOD, default 2**WIDTH-1: period loaded at reset, expressed as terminal count.
REQ-004 Parameter DEADTIME, default 2: dead-time length in clk cycles, 1..15; used only when PWM_BANK_DEADTIME_EN is defined.
REQ-005 Port clk, input, 1: single clock for the whole block.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port wr_en, input, 1: shadow write strobe, one write per asserted cycle.
REQ-008 Port wr_sel, input, clog2(CHANNELS+1): channel index 0..CHANNELS-1 targets duty/offset; index CHANNELS targets the period.
REQ-009 Port wr_duty, input, WIDTH: duty value, or period value when wr_sel==CHANNELS.
REQ-010 Port wr_offset, input, WIDTH: phase offset; ignored when wr_sel==CHANNELS.
REQ-011 Port commit, input, 1: request to transfer all shadow registers to active at the next wrap.
REQ-012 Port commit_pending, output, 1: commit requested but not yet applied.
REQ-013 Port period_end, output, 1: one-cycle pulse on each counter wrap.
REQ-014 Port out, output, CHANNELS: PWM outputs, registered.
REQ-015 Port out_n, output, CHANNELS: complementary outputs with dead time, registered.

Function
REQ-016 Shared counter cnt counts 0..active_period, then wraps to 0.
REQ-017 Raw channel level: high when ((cnt - offset) mod (active_period+1)) < duty, computed with WIDTH+1-bit arithmetic, with no truncation at period=2**WIDTH-1.
REQ-018 Boundary: duty=0 gives constant low; duty>active_period gives constant high; offset>active_period gives constant low.
REQ-019 Offset wrap: the high window continues across the cnt wrap, e.g. period=9, offset=8, duty=4 gives high at cnt 8,9,0,1.
REQ-020 Latency: out[i] at cycle t+1 reflects the raw level computed from cnt at cycle t.
REQ-021 period_end asserts in the cycle after cnt==active_period, for exactly one cycle.
REQ-022 A wr_en write updates only the shadow register; active values are unchanged.
REQ-023 commit sets commit_pending; commit_pending clears on the edge where cnt wraps, and on that same edge all active registers load from the shadow registers.
REQ-024 commit in the same cycle as the wrap (cnt==active_period) is applied on that wrap.
REQ-025 wr_en on the wrap edge: the load uses shadow contents from before the write; the new value waits for the next commit.
REQ-026 commit while commit_pending is already high has no additional effect.
REQ-027 A period shrink at commit cannot strand the counter, because the load only happens at cnt=0.

Reset
REQ-028 rst asynchronously forces the following, all channels: cnt=0; active and shadow duty=0 and offset=0; active and shadow period=DEFAULT_PERIOD; commit_pending=0; period_end=0; out=0; out_n=0; dead-time counters=0.
REQ-029 Reset mid-period abandons any pending commit; counting restarts at cnt=0 on the first clk edge after rst deasserts.

Configuration
REQ-030 Macro PWM_BANK_DEADTIME_EN defined:
- out[i] rises only after raw has been high for DEADTIME consecutive cycles.
- out_n[i] rises only after raw has been low for DEADTIME consecutive cycles.
- Both outputs fall immediately on the opposite raw edge.
- out and out_n are never high together.
REQ-031 Macro PWM_BANK_DEADTIME_EN undefined: out follows raw per REQ-020; out_n is constant 0; no dead-time logic is synthesised.

Structure
REQ-032 Package pwm_bank_pkg holds the DEADTIME counter width constant and the period-select encoding helper (index CHANNELS).
REQ-033 Sub-module pwm_bank_channel, instantiated CHANNELS times, holds:
- shadow and active duty/offset registers;
- the comparator;
- the output register;
- the dead-time counter.
REQ-034 The shared counter, period registers and commit logic live in pwm_bank.

Verification
REQ-035 Reset defaults: release rst, no writes -> out=0, out_n=0, and period_end pulses every 256 cycles.
REQ-036 Complementary pair:
- Stimulus: period=9; ch0 duty=5 offset=0; ch1 duty=5 offset=5; commit.
- Response: after the next wrap, out[0] is high at cnt 0-4, out[1] is high at cnt 5-9, and out[0]&out[1] is always 0.
REQ-037 Boundaries: with period=9, duty=0 -> low always; duty=10 -> high always; offset=8 duty=4 -> high at cnt 8,9,0,1.
REQ-038 Commit timing:
- A write at cnt=3 without commit -> no output change.
- A commit at cnt=3 -> change appears exactly at cnt=0, and commit_pending falls on the same edge.
- commit asserted at cnt=9 is applied on that same wrap.
REQ-039 Dead time (macro defined, DEADTIME=2, period=9, duty=5) -> per period, out is high 3 cycles, out_n is high 3 cycles, with two 2-cycle both-low gaps.
REQ-040 Reset mid-operation: assert rst at cnt=6 with commit pending, asynchronously to clk -> outputs drop to 0 immediately, commit_pending=0, and old shadow values are discarded.
